mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back selection for the MIPS datapath.
//  Sits directly downstream of the memory-access stage. Latches the ALU result,
//  load data and control bits, then drives the register-file write port.
//  Also provides the forwarding source for EX, halt detection for the debug unit,
//  and an optional retired-instruction counter.
// PARAMETERS
//  NBITS  32  datapath width (ALU result, load data, PC+8, write-back data)
//  RBITS  5   register-index width
// PORTS
//  i_clk         in   1      system clock, rising edge
//  i_rst         in   1      synchronous reset, active-low (0 = reset)
//  i_step        in   1      pipeline advance enable (debug single-step / run)
//  i_flush       in   1      insert bubble instead of incoming instruction
//  i_valid       in   1      incoming MEM-stage slot holds a real instruction
//  i_ALU_rslt    in   NBITS  ALU result from MEM stage
//  i_mem_data    in   NBITS  load data from data memory (already sign/zero-extended)
//  i_pc_plus8    in   NBITS  link address for JAL/JALR
//  i_rd          in   RBITS  destination register index
//  i_reg_wr_en   in   1      instruction writes the register file
//  i_wb_sel      in   2      00 ALU, 01 MEM, 10 PC+8, 11 ALU (reserved)
//  i_halt        in   1      instruction is HALT
//  o_wb_data     out  NBITS  register-file write data / forwarding data
//  o_wb_rd       out  RBITS  register-file write index / forwarding index
//  o_wb_wr_en    out  1      register-file write enable / forwarding valid
//  o_valid       out  1      WB slot holds a real instruction
//  o_halted      out  1      sticky: HALT has reached WB
//  o_retired     out  32     retired-instruction count (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset (i_rst=0 at edge): all internal regs 0 -> o_wb_data=0, o_wb_rd=0,
//    o_wb_wr_en=0, o_valid=0, o_halted=0, o_retired=0. Reset beats all other inputs.
//  - Advance condition: adv = i_step & ~o_halted. No adv -> all regs hold.
//  - On adv, load: bubble if (i_flush | ~i_valid); else capture all inputs.
//    Bubble: valid=0, reg_wr_en=0, halt=0, rd=0, data regs=0.
//  - Latency: one adv edge from MEM inputs to WB outputs.
//  - o_wb_data combinational from latched regs via wb_sel mux; 11 selects ALU.
//  - o_wb_wr_en = valid & reg_wr_en & (rd != 0); writes to r0 are suppressed.
//  - o_wb_rd = latched rd (0 for bubbles).
//  - Halt: on adv with captured halt=1, o_halted rises the same edge as o_valid;
//    stays 1 until reset; HALT itself never writes (wr_en forced 0 when halt).
//    Once halted, i_step ignored; outputs frozen on the HALT slot.
//  - i_flush together with i_halt: flush wins, no halt recorded.
//  - Reset asserted while halted or mid-step: clears everything, counter included.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: o_retired port exists; 32-bit counter increments
//   on every adv edge that captures a non-bubble instruction (HALT counts),
//   saturates at 32'hFFFF_FFFF (no wrap), cleared by reset.
//  WB_RETIRE_CNT_EN undefined: counter logic and o_retired port are absent;
//   all other behaviour identical.
// TESTING
//  1 Reset: drive junk inputs, i_rst=0 for 2 cycles -> every output 0.
//  2 ALU write: valid=1, rd=5, wr_en=1, sel=00, ALU=0x1234, step -> next cycle
//    o_wb_data=0x1234, o_wb_rd=5, o_wb_wr_en=1; sel=01 mem=0xFFFF_FF80 -> 0xFFFF_FF80;
//    sel=10 pc8=0x40 -> 0x40; sel=11 -> ALU value.
//  3 r0/stall: rd=0 wr_en=1 -> o_wb_wr_en=0; then i_step=0 with new inputs ->
//    outputs unchanged for 3 cycles.
//  4 Flush: valid=1 rd=7 wr_en=1 halt=1 with i_flush=1, step -> o_valid=0,
//    o_wb_wr_en=0, o_halted=0, retire count unchanged.
//  5 Halt: step HALT -> o_halted=1, o_wb_wr_en=0; further steps with rd=3
//    wr_en=1 -> outputs frozen; i_rst=0 -> o_halted=0.
//  6 Counter (EN): 10 valid steps + 3 bubbles -> o_retired=10; force count
//    to 0xFFFF_FFFF, one more valid step -> stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back source selection, halt latch and
// an optional saturating retired-instruction counter (macro WB_RETIRE_CNT_EN).
module mem_wb_stage #(
  parameter int NBITS = 32,
  parameter int RBITS = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [NBITS-1:0] i_ALU_rslt,
  input  logic [NBITS-1:0] i_mem_data,
  input  logic [NBITS-1:0] i_pc_plus8,
  input  logic [RBITS-1:0] i_rd,
  input  logic             i_reg_wr_en,
  input  logic [1:0]       i_wb_sel,
  input  logic             i_halt,
  output logic [NBITS-1:0] o_wb_data,
  output logic [RBITS-1:0] o_wb_rd,
  output logic             o_wb_wr_en,
  output logic             o_valid,
  output logic             o_halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]      o_retired
`endif
);

  logic             valid_q,  valid_d;
  logic             wr_en_q,  wr_en_d;
  logic             halted_q, halted_d;
  logic [RBITS-1:0] rd_q,     rd_d;
  logic [1:0]       sel_q,    sel_d;
  logic [NBITS-1:0] alu_q,    alu_d;
  logic [NBITS-1:0] mem_q,    mem_d;
  logic [NBITS-1:0] pc8_q,    pc8_d;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0]      retired_q, retired_d;
`endif

  logic adv;
  logic capture;

  // Once HALT sits in WB the stage freezes until reset.
  assign adv     = i_step & ~halted_q;
  assign capture = adv & i_valid & ~i_flush;

  always_comb begin
    valid_d  = valid_q;
    wr_en_d  = wr_en_q;
    halted_d = halted_q;
    rd_d     = rd_q;
    sel_d    = sel_q;
    alu_d    = alu_q;
    mem_d    = mem_q;
    pc8_d    = pc8_q;
`ifdef WB_RETIRE_CNT_EN
    retired_d = retired_q;
`endif
    if (adv) begin
      // Bubbles load all-zero so forwarding sees a clean rd=0 slot.
      valid_d  = capture;
      wr_en_d  = capture & i_reg_wr_en;
      halted_d = capture & i_halt;
      rd_d     = capture ? i_rd       : '0;
      sel_d    = capture ? i_wb_sel   : '0;
      alu_d    = capture ? i_ALU_rslt : '0;
      mem_d    = capture ? i_mem_data : '0;
      pc8_d    = capture ? i_pc_plus8 : '0;
`ifdef WB_RETIRE_CNT_EN
      if (capture && (retired_q != 32'hFFFF_FFFF)) retired_d = retired_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      valid_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      halted_q <= 1'b0;
      rd_q     <= '0;
      sel_q    <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
      pc8_q    <= '0;
`ifdef WB_RETIRE_CNT_EN
      retired_q <= '0;
`endif
    end else begin
      valid_q  <= valid_d;
      wr_en_q  <= wr_en_d;
      halted_q <= halted_d;
      rd_q     <= rd_d;
      sel_q    <= sel_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      pc8_q    <= pc8_d;
`ifdef WB_RETIRE_CNT_EN
      retired_q <= retired_d;
`endif
    end
  end

  always_comb begin
    o_wb_data = alu_q;
    case (sel_q)
      2'b01:   o_wb_data = mem_q;
      2'b10:   o_wb_data = pc8_q;
      default: o_wb_data = alu_q;
    endcase
  end

  // HALT never writes, and r0 is hard-wired so its writes are dropped.
  assign o_wb_wr_en = valid_q & wr_en_q & (rd_q != '0) & ~halted_q;
  assign o_wb_rd    = rd_q;
  assign o_valid    = valid_q;
  assign o_halted   = halted_q;
`ifdef WB_RETIRE_CNT_EN
  assign o_retired  = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; counter checks are built
// only when WB_RETIRE_CNT_EN is defined.
module tb_mem_wb_stage;

  logic        i_clk = 1'b0;
  logic        i_rst, i_step, i_flush, i_valid;
  logic [31:0] i_ALU_rslt, i_mem_data, i_pc_plus8;
  logic [4:0]  i_rd;
  logic        i_reg_wr_en;
  logic [1:0]  i_wb_sel;
  logic        i_halt;
  logic [31:0] o_wb_data;
  logic [4:0]  o_wb_rd;
  logic        o_wb_wr_en, o_valid, o_halted;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] o_retired;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  mem_wb_stage #(.NBITS(32), .RBITS(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_step(i_step), .i_flush(i_flush),
    .i_valid(i_valid), .i_ALU_rslt(i_ALU_rslt), .i_mem_data(i_mem_data),
    .i_pc_plus8(i_pc_plus8), .i_rd(i_rd), .i_reg_wr_en(i_reg_wr_en),
    .i_wb_sel(i_wb_sel), .i_halt(i_halt), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_wr_en(o_wb_wr_en), .o_valid(o_valid),
    .o_halted(o_halted)
`ifdef WB_RETIRE_CNT_EN
    , .o_retired(o_retired)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic slot(input logic v, input logic [4:0] rd, input logic we,
                      input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] pc8, input logic h);
    i_valid = v; i_rd = rd; i_reg_wr_en = we; i_wb_sel = sel;
    i_ALU_rslt = alu; i_mem_data = mem; i_pc_plus8 = pc8; i_halt = h;
  endtask

  initial begin
    // 1: reset with junk inputs and step asserted
    i_rst = 1'b0; i_step = 1'b1; i_flush = 1'b0;
    slot(1'b1, 5'd17, 1'b1, 2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1111_2222, 1'b1);
    tick(); tick();
    chk("rst_data",   o_wb_data,  32'h0);
    chk("rst_rd",     {27'd0, o_wb_rd}, 32'h0);
    chk("rst_wr_en",  {31'd0, o_wb_wr_en}, 32'h0);
    chk("rst_valid",  {31'd0, o_valid}, 32'h0);
    chk("rst_halted", {31'd0, o_halted}, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retired", o_retired, 32'h0);
`endif

    // 2: write-back source selection
    i_rst = 1'b1;
    slot(1'b1, 5'd5, 1'b1, 2'b00, 32'h1234, 32'hAAAA_0000, 32'hBBBB_0000, 1'b0);
    tick();
    chk("alu_data",  o_wb_data, 32'h1234);
    chk("alu_rd",    {27'd0, o_wb_rd}, 32'd5);
    chk("alu_wr_en", {31'd0, o_wb_wr_en}, 32'd1);
    chk("alu_valid", {31'd0, o_valid}, 32'd1);
    slot(1'b1, 5'd5, 1'b1, 2'b01, 32'h1234, 32'hFFFF_FF80, 32'hBBBB_0000, 1'b0);
    tick();
    chk("mem_data", o_wb_data, 32'hFFFF_FF80);
    slot(1'b1, 5'd6, 1'b1, 2'b10, 32'h1234, 32'hFFFF_FF80, 32'h40, 1'b0);
    tick();
    chk("pc8_data", o_wb_data, 32'h40);
    chk("pc8_rd",   {27'd0, o_wb_rd}, 32'd6);
    slot(1'b1, 5'd6, 1'b1, 2'b11, 32'hABCD, 32'hFFFF_FF80, 32'h40, 1'b0);
    tick();
    chk("sel11_data", o_wb_data, 32'hABCD);

    // 3: r0 write suppression, then stall
    slot(1'b1, 5'd0, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0, 1'b0);
    tick();
    chk("r0_wr_en", {31'd0, o_wb_wr_en}, 32'd0);
    chk("r0_valid", {31'd0, o_valid}, 32'd1);
    chk("r0_data",  o_wb_data, 32'h77);
    i_step = 1'b0;
    slot(1'b1, 5'd9, 1'b1, 2'b00, 32'h5555, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", o_wb_data, 32'h77);
      chk("stall_rd",   {27'd0, o_wb_rd}, 32'd0);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("stall_retired", o_retired, 32'd5);
`endif

    // 4: flush beats halt; invalid slot is a bubble
    i_step = 1'b1; i_flush = 1'b1;
    slot(1'b1, 5'd7, 1'b1, 2'b00, 32'h7777, 32'h0, 32'h0, 1'b1);
    tick();
    chk("flush_valid",  {31'd0, o_valid}, 32'd0);
    chk("flush_wr_en",  {31'd0, o_wb_wr_en}, 32'd0);
    chk("flush_halted", {31'd0, o_halted}, 32'd0);
    chk("flush_rd",     {27'd0, o_wb_rd}, 32'd0);
    chk("flush_data",   o_wb_data, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    chk("flush_retired", o_retired, 32'd5);
`endif
    i_flush = 1'b0;
    slot(1'b0, 5'd8, 1'b1, 2'b00, 32'h8888, 32'h0, 32'h0, 1'b0);
    tick();
    chk("bubble_valid", {31'd0, o_valid}, 32'd0);
    chk("bubble_wr_en", {31'd0, o_wb_wr_en}, 32'd0);

    // 5: halt freezes the stage until reset
    slot(1'b1, 5'd4, 1'b1, 2'b00, 32'h99, 32'h0, 32'h0, 1'b1);
    tick();
    chk("halt_halted", {31'd0, o_halted}, 32'd1);
    chk("halt_valid",  {31'd0, o_valid}, 32'd1);
    chk("halt_wr_en",  {31'd0, o_wb_wr_en}, 32'd0);
    chk("halt_rd",     {27'd0, o_wb_rd}, 32'd4);
    slot(1'b1, 5'd3, 1'b1, 2'b00, 32'h3333, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("frozen_data",   o_wb_data, 32'h99);
      chk("frozen_rd",     {27'd0, o_wb_rd}, 32'd4);
      chk("frozen_wr_en",  {31'd0, o_wb_wr_en}, 32'd0);
      chk("frozen_halted", {31'd0, o_halted}, 32'd1);
    end
`ifdef WB_RETIRE_CNT_EN
    chk("halt_retired", o_retired, 32'd6);
`endif
    i_rst = 1'b0;
    tick();
    chk("unhalt_halted", {31'd0, o_halted}, 32'd0);
    chk("unhalt_valid",  {31'd0, o_valid}, 32'd0);
    chk("unhalt_data",   o_wb_data, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    chk("unhalt_retired", o_retired, 32'd0);

    // 6: retire counter and saturation
    i_rst = 1'b1;
    slot(1'b1, 5'd2, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    slot(1'b0, 5'd2, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    chk("cnt_ten", o_retired, 32'd10);
    i_step = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    i_step = 1'b1;
    slot(1'b1, 5'd2, 1'b1, 2'b00, 32'h1, 32'h0, 32'h0, 1'b0);
    tick();
    chk("cnt_sat", o_retired, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
